// File: rtl/ifetch_unit_if.sv
// Instruction-fetch bus: memory address/data, redirect request and decode handshake.
// master = fetch unit side, slave = memory/branch/decode environment side.
// Ports: im_addr/im_q (memory), redirect_valid/redirect_addr, instr_valid/instr/instr_pc/instr_ready.
interface ifetch_unit_if #(
    parameter int IM_ADDRESS_WIDTH  = 6,
    parameter int INSTRUCTION_WIDTH = 32
);
    logic [IM_ADDRESS_WIDTH-1:0]  im_addr;
    logic [INSTRUCTION_WIDTH-1:0] im_q;
    logic                         redirect_valid;
    logic [IM_ADDRESS_WIDTH-1:0]  redirect_addr;
    logic                         instr_valid;
    logic [INSTRUCTION_WIDTH-1:0] instr;
    logic [IM_ADDRESS_WIDTH-1:0]  instr_pc;
    logic                         instr_ready;

    modport master (
        output im_addr,
        input  im_q,
        input  redirect_valid,
        input  redirect_addr,
        output instr_valid,
        output instr,
        output instr_pc,
        input  instr_ready
    );

    modport slave (
        input  im_addr,
        output im_q,
        output redirect_valid,
        output redirect_addr,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction prefetcher: streams sequential words from a 1-cycle-latency memory into a small buffer.
// Latency: read issued in cycle N, pushed at end of N+1, visible at the head in N+2; one instr/cycle sustained.
// Backpressure: reads stop while buffered + in-flight entries reach FIFO_DEPTH; redirect flushes everything.
// Ports: clk, rst (sync, active-high), bus (ifetch_unit_if.master: memory, redirect, decode handshake).
module ifetch_unit #(
    parameter int IM_ADDRESS_WIDTH  = 6,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic          clk,
    input  logic          rst,
    ifetch_unit_if.master bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                         state;
    logic [IM_ADDRESS_WIDTH-1:0]    fetch_pc;
    logic [IM_ADDRESS_WIDTH-1:0]    tag;
    logic                           inflight;
    logic [CNT_W-1:0]               count;
    logic [PTR_W-1:0]               wr_ptr;
    logic [PTR_W-1:0]               rd_ptr;
    logic [IM_ADDRESS_WIDTH-1:0]    pc_buf  [FIFO_DEPTH];
    logic [INSTRUCTION_WIDTH-1:0]   ins_buf [FIFO_DEPTH];

    logic           flush;
    logic           issue;
    logic           push;
    logic           pop;
    logic           head_vld;
    logic [CNT_W:0] occupancy;

    // In-flight read reserves a slot so its response always has room to land.
    assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign flush     = (state == RUN) && bus.redirect_valid;
    assign issue     = (state == RUN) && !bus.redirect_valid && (occupancy < DEPTH_LIM);
    assign push      = inflight && !flush;
    assign head_vld  = (count != '0);
    assign pop       = head_vld && bus.instr_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= '0;
            tag      <= '0;
            inflight <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else if (state == IDLE) begin
            state <= RUN;
        end else if (flush) begin
            // The word returning this cycle belongs to the old stream and is dropped.
            fetch_pc <= bus.redirect_addr;
            inflight <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                tag      <= fetch_pc;
                fetch_pc <= fetch_pc + IM_ADDRESS_WIDTH'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: outputs are masked to zero whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            pc_buf[wr_ptr]  <= tag;
            ins_buf[wr_ptr] <= bus.im_q;
        end
    end

    assign bus.im_addr     = fetch_pc;
    assign bus.instr_valid = head_vld;
    assign bus.instr       = head_vld ? ins_buf[rd_ptr] : '0;
    assign bus.instr_pc    = head_vld ? pc_buf[rd_ptr] : '0;
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: cycle table for start-up/streaming plus hand-written redirect,
// back-pressure, wrap and mid-stream reset sequences; delivered instructions are
// checked in order against a scoreboard queue filled when the stimulus is chosen.
module tb_ifetch_unit;
    localparam int AW = 6;
    localparam int IW = 32;
    localparam int NROWS = 11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ifetch_unit_if #(.IM_ADDRESS_WIDTH(AW), .INSTRUCTION_WIDTH(IW)) bus ();

    ifetch_unit #(
        .IM_ADDRESS_WIDTH (AW),
        .INSTRUCTION_WIDTH(IW),
        .FIFO_DEPTH       (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Instruction memory: 1-cycle synchronous read.
    logic [IW-1:0] mem [64];
    always @(posedge clk) bus.im_q <= mem[bus.im_addr];

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] w;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic          rst;
        logic          rv;
        logic [AW-1:0] ra;
        logic          rdy;
        logic          ev;
        logic [AW-1:0] epc;
        logic [AW-1:0] eaddr;
    } vec_t;
    vec_t tbl[NROWS];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic expect_pc(input logic [AW-1:0] p);
        exp_t e;
        e.pc = p;
        e.w  = mem[p];
        sb.push_back(e);
    endtask

    // Drive one cycle's inputs at the negedge, score any transfer happening at the
    // coming posedge, then return at the following negedge with outputs settled.
    task automatic cyc(input logic r, input logic rv, input logic [AW-1:0] ra, input logic rdy);
        exp_t e;
        rst                = r;
        bus.redirect_valid = rv;
        bus.redirect_addr  = ra;
        bus.instr_ready    = rdy;
        #1;
        if (!r && !rv && rdy && bus.instr_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xfer: got pc %0d, scoreboard empty", bus.instr_pc);
            end else begin
                e = sb.pop_front();
                chk("xfer_pc", 32'(bus.instr_pc), 32'(e.pc));
                chk("xfer_instr", bus.instr, e.w);
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int budget = 40;
        while (sb.size() != 0 && budget > 0) begin
            cyc(1'b0, 1'b0, '0, 1'b1);
            budget--;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic run_table(input int start);
        for (int i = start; i < NROWS; i++) begin
            cyc(tbl[i].rst, tbl[i].rv, tbl[i].ra, tbl[i].rdy);
            chk($sformatf("tbl%0d_valid", i), 32'(bus.instr_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_pc", i), 32'(bus.instr_pc), tbl[i].ev ? 32'(tbl[i].epc) : 32'd0);
            chk($sformatf("tbl%0d_addr", i), 32'(bus.im_addr), 32'(tbl[i].eaddr));
            chk($sformatf("tbl%0d_instr", i), bus.instr, tbl[i].ev ? mem[tbl[i].epc] : 32'd0);
        end
    endtask

    task automatic hold_off(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = '0;
        bus.instr_ready    = 1'b0;

        for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
        mem[0] = 32'h00A62020;
        mem[1] = 32'h00A62022;
        mem[2] = 32'h00A62023;
        mem[3] = 32'h20E8FFF6;
        mem[4] = 32'h28E8FFFE;
        mem[5] = 32'h01063824;

        //            rst   rv    ra  rdy   ev   epc eaddr
        tbl[0]  = '{1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 6'd0, 6'd0};
        tbl[1]  = '{1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 6'd0, 6'd0};
        tbl[2]  = '{1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 6'd0, 6'd0};
        tbl[3]  = '{1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 6'd0, 6'd1};
        tbl[4]  = '{1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 6'd0, 6'd2};
        tbl[5]  = '{1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 6'd1, 6'd3};
        tbl[6]  = '{1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 6'd2, 6'd4};
        tbl[7]  = '{1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 6'd3, 6'd5};
        tbl[8]  = '{1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 6'd4, 6'd6};
        tbl[9]  = '{1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 6'd5, 6'd7};
        tbl[10] = '{1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 6'd6, 6'd8};

        @(negedge clk);

        // Reset state and streaming start-up.
        for (int p = 0; p < 6; p++) expect_pc(AW'(p));
        run_table(0);
        chk("stream_sb_empty", 32'(sb.size()), 32'd0);

        // Redirect while a transfer and a push coincide (head pc 6, pc 7 in flight).
        cyc(1'b0, 1'b1, 6'd40, 1'b1);
        chk("rdx_xfer_valid", 32'(bus.instr_valid), 32'd0);
        chk("rdx_xfer_addr", 32'(bus.im_addr), 32'd40);
        cyc(1'b0, 1'b0, '0, 1'b1);
        chk("rdx_xfer_valid2", 32'(bus.instr_valid), 32'd0);
        chk("rdx_xfer_addr2", 32'(bus.im_addr), 32'd41);
        cyc(1'b0, 1'b0, '0, 1'b0);
        chk("rdx_xfer_head_pc", 32'(bus.instr_pc), 32'd40);
        for (int p = 40; p < 43; p++) expect_pc(AW'(p));
        drain();

        // Back-pressure: hold ready low for 10 cycles, head must not move.
        cyc(1'b1, 1'b0, '0, 1'b0);
        chk("bp_reset_valid", 32'(bus.instr_valid), 32'd0);
        for (int k = 1; k <= 10; k++) begin
            cyc(1'b0, 1'b0, '0, 1'b0);
            if (k >= 3) begin
                chk($sformatf("bp_valid_%0d", k), 32'(bus.instr_valid), 32'd1);
                chk($sformatf("bp_head_%0d", k), 32'(bus.instr_pc), 32'd0);
            end
            if (k >= 6) chk($sformatf("bp_addr_%0d", k), 32'(bus.im_addr), 32'd4);
        end
        chk("bp_head_instr", bus.instr, 32'h00A62020);
        for (int p = 0; p < 6; p++) expect_pc(AW'(p));
        drain();

        // Redirect to 2 with a full buffer holding pcs 0..3.
        cyc(1'b1, 1'b0, '0, 1'b0);
        hold_off(10);
        chk("rd_full_head", 32'(bus.instr_pc), 32'd0);
        cyc(1'b0, 1'b1, 6'd2, 1'b0);
        chk("rd_valid0", 32'(bus.instr_valid), 32'd0);
        chk("rd_addr0", 32'(bus.im_addr), 32'd2);
        cyc(1'b0, 1'b0, '0, 1'b0);
        chk("rd_valid1", 32'(bus.instr_valid), 32'd0);
        cyc(1'b0, 1'b0, '0, 1'b0);
        chk("rd_valid2", 32'(bus.instr_valid), 32'd1);
        chk("rd_pc2", 32'(bus.instr_pc), 32'd2);
        chk("rd_instr2", bus.instr, 32'h00A62023);
        for (int p = 2; p < 6; p++) expect_pc(AW'(p));
        drain();

        // Wrap-around of the fetch address.
        cyc(1'b0, 1'b1, 6'd62, 1'b1);
        chk("wrap_addr", 32'(bus.im_addr), 32'd62);
        chk("wrap_valid", 32'(bus.instr_valid), 32'd0);
        expect_pc(6'd62);
        expect_pc(6'd63);
        expect_pc(6'd0);
        expect_pc(6'd1);
        drain();

        // Mid-stream reset with a full buffer, then restart from pc 0.
        hold_off(10);
        chk("mr_full_valid", 32'(bus.instr_valid), 32'd1);
        cyc(1'b1, 1'b0, '0, 1'b0);
        chk("mr_valid", 32'(bus.instr_valid), 32'd0);
        chk("mr_addr", 32'(bus.im_addr), 32'd0);
        chk("mr_pc", 32'(bus.instr_pc), 32'd0);
        chk("mr_instr", bus.instr, 32'd0);
        for (int p = 0; p < 6; p++) expect_pc(AW'(p));
        run_table(2);
        chk("mr_sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
